// File: rtl/accum_tile_sequencer_if.sv
// Handshake bundle between the tile sequencer and the array/accumulator control.
// The slave modport is the sequencer side; the master modport is the driving side.
interface accum_tile_sequencer_if #(
   parameter int unsigned N      = 32,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned TILE_W = 4
);
   logic              start_i;
   logic [TILE_W-1:0] cfg_rows_i;
   logic [TILE_W-1:0] cfg_ksteps_i;
   logic [ADDR_W-1:0] acc_base_i;
   logic              mac_valid_i;
   logic              flush_i;
   logic              busy_o;
   logic              done_o;
   logic              cfg_err_o;
   logic              rd_en_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic              wr_en_o;
   logic [ADDR_W-1:0] wr_addr_o;
   logic [N-1:0]      wr_mask_o;
   logic              add_en_o;
   logic [TILE_W-1:0] pass_o;

   modport slave (
      input  start_i, cfg_rows_i, cfg_ksteps_i, acc_base_i, mac_valid_i, flush_i,
      output busy_o, done_o, cfg_err_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o,
             wr_mask_o, add_en_o, pass_o
   );

   modport master (
      output start_i, cfg_rows_i, cfg_ksteps_i, acc_base_i, mac_valid_i, flush_i,
      input  busy_o, done_o, cfg_err_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o,
             wr_mask_o, add_en_o, pass_o
   );
endinterface

// File: rtl/accum_tile_sequencer.sv
// Sequences accumulator read/write addresses and column masks for an N x N systolic
// array across K reduction passes of L = rows*N output rows.
module accum_tile_sequencer #(
   parameter int unsigned N         = 32,
   parameter int unsigned ACC_DEPTH = 1024,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned TILE_W    = 4
) (
   input logic                  clk_i,
   input logic                  rst_i,
   accum_tile_sequencer_if.slave bus
);

   localparam int unsigned NL = $clog2(N);
   localparam int unsigned CW = ADDR_W + TILE_W + NL + 2;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [NL:0]   fill_t;

   localparam logic [N-1:0] Ones = {N{1'b1}};

   typedef enum logic [2:0] {StIdle, StFill, StRampIn, StSteady, StRampOut} state_e;

   state_e            state_q, state_d;
   cnt_t              t_q, t_d;
   fill_t             fill_q, fill_d;
   logic [TILE_W-1:0] pass_q, pass_d;
   logic [TILE_W-1:0] kmax_q, kmax_d;
   cnt_t              len_q, len_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              err_q, err_d;

   // Stage 1 = issue (read request), stage 2 = write.
   logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d;
   logic              s1_add_q, s1_add_d, s2_add_q, s2_add_d;
   logic              s1_last_q, s1_last_d, s2_last_q, s2_last_d;
   logic [ADDR_W-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
   logic [N-1:0]      s1_mask_q, s1_mask_d, s2_mask_q, s2_mask_d;
   logic [TILE_W-1:0] s1_pass_q, s1_pass_d, s2_pass_q, s2_pass_d;

   logic   idle, issue, final_pass, last_t;
   cnt_t   len_new, end_new;
   logic   cfg_bad;
   logic [N-1:0] mask_cur;

   assign idle       = (state_q == StIdle) && !s1_v_q && !s2_v_q;
   assign issue      = bus.mac_valid_i &&
                       (state_q inside {StRampIn, StSteady, StRampOut});
   assign final_pass = (pass_q == kmax_q - TILE_W'(1));
   assign last_t     = (t_q == len_q + cnt_t'(N - 2));

   assign len_new = cnt_t'(bus.cfg_rows_i) << NL;
   assign end_new = cnt_t'(bus.acc_base_i) + len_new + cnt_t'(N - 1);
   assign cfg_bad = (bus.cfg_rows_i == '0) || (bus.cfg_ksteps_i == '0) ||
                    (end_new > cnt_t'(ACC_DEPTH));

   always_comb begin
      mask_cur = '0;
      unique case (state_q)
         StRampIn:  mask_cur = ~(Ones >> (t_q + cnt_t'(1)));
         StSteady:  mask_cur = Ones;
         StRampOut: mask_cur = Ones >> (t_q - len_q + cnt_t'(1));
         default:   mask_cur = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      t_d       = t_q;
      fill_d    = fill_q;
      pass_d    = pass_q;
      kmax_d    = kmax_q;
      len_d     = len_q;
      base_d    = base_q;
      err_d     = 1'b0;
      s1_v_d    = 1'b0;
      s1_add_d  = 1'b0;
      s1_last_d = 1'b0;
      s1_addr_d = '0;
      s1_mask_d = '0;
      s1_pass_d = '0;
      s2_v_d    = s1_v_q;
      s2_add_d  = s1_add_q;
      s2_last_d = s1_last_q;
      s2_addr_d = s1_addr_q;
      s2_mask_d = s1_mask_q;
      s2_pass_d = s1_pass_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start_i && idle) begin
               base_d = bus.acc_base_i;
               len_d  = len_new;
               kmax_d = bus.cfg_ksteps_i;
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = StFill;
                  pass_d  = '0;
                  fill_d  = '0;
                  t_d     = '0;
               end
            end
         end
         StFill: begin
            if (bus.mac_valid_i) begin
               if (fill_q == fill_t'(N - 1)) begin
                  state_d = StRampIn;
                  fill_d  = '0;
                  t_d     = '0;
               end else begin
                  fill_d = fill_q + fill_t'(1);
               end
            end
         end
         StRampIn: begin
            if (bus.mac_valid_i) begin
               t_d = t_q + cnt_t'(1);
               if (t_q == cnt_t'(N - 2)) state_d = StSteady;
            end
         end
         StSteady: begin
            if (bus.mac_valid_i) begin
               t_d = t_q + cnt_t'(1);
               if (t_q == len_q - cnt_t'(1)) state_d = StRampOut;
            end
         end
         StRampOut: begin
            if (bus.mac_valid_i) begin
               if (last_t) begin
                  t_d = '0;
                  if (final_pass) begin
                     state_d = StIdle;
                  end else begin
                     pass_d  = pass_q + TILE_W'(1);
                     state_d = StFill;
                  end
               end else begin
                  t_d = t_q + cnt_t'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (issue) begin
         s1_v_d    = 1'b1;
         s1_add_d  = (pass_q != '0);
         s1_last_d = (state_q == StRampOut) && last_t && final_pass;
         s1_addr_d = base_q + t_q[ADDR_W-1:0];
         s1_mask_d = mask_cur;
         s1_pass_d = pass_q;
      end

      // Flush wins over everything, including in-flight pipeline contents.
      if (bus.flush_i) begin
         state_d   = StIdle;
         t_d       = '0;
         fill_d    = '0;
         pass_d    = '0;
         err_d     = 1'b0;
         s1_v_d    = 1'b0;
         s1_add_d  = 1'b0;
         s1_last_d = 1'b0;
         s1_addr_d = '0;
         s1_mask_d = '0;
         s1_pass_d = '0;
         s2_v_d    = 1'b0;
         s2_add_d  = 1'b0;
         s2_last_d = 1'b0;
         s2_addr_d = '0;
         s2_mask_d = '0;
         s2_pass_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         t_q       <= '0;
         fill_q    <= '0;
         pass_q    <= '0;
         kmax_q    <= '0;
         len_q     <= '0;
         base_q    <= '0;
         err_q     <= 1'b0;
         s1_v_q    <= 1'b0;
         s1_add_q  <= 1'b0;
         s1_last_q <= 1'b0;
         s1_addr_q <= '0;
         s1_mask_q <= '0;
         s1_pass_q <= '0;
         s2_v_q    <= 1'b0;
         s2_add_q  <= 1'b0;
         s2_last_q <= 1'b0;
         s2_addr_q <= '0;
         s2_mask_q <= '0;
         s2_pass_q <= '0;
      end else begin
         state_q   <= state_d;
         t_q       <= t_d;
         fill_q    <= fill_d;
         pass_q    <= pass_d;
         kmax_q    <= kmax_d;
         len_q     <= len_d;
         base_q    <= base_d;
         err_q     <= err_d;
         s1_v_q    <= s1_v_d;
         s1_add_q  <= s1_add_d;
         s1_last_q <= s1_last_d;
         s1_addr_q <= s1_addr_d;
         s1_mask_q <= s1_mask_d;
         s1_pass_q <= s1_pass_d;
         s2_v_q    <= s2_v_d;
         s2_add_q  <= s2_add_d;
         s2_last_q <= s2_last_d;
         s2_addr_q <= s2_addr_d;
         s2_mask_q <= s2_mask_d;
         s2_pass_q <= s2_pass_d;
      end
   end

   assign bus.busy_o    = (state_q != StIdle) || s1_v_q || s2_v_q;
   assign bus.done_o    = s2_last_q;
   assign bus.cfg_err_o = err_q;
   assign bus.rd_en_o   = s1_v_q && s1_add_q;
   assign bus.rd_addr_o = (s1_v_q && s1_add_q) ? s1_addr_q : '0;
   assign bus.wr_en_o   = s2_v_q;
   assign bus.wr_addr_o = s2_addr_q;
   assign bus.wr_mask_o = s2_mask_q;
   assign bus.add_en_o  = s2_add_q;
   assign bus.pass_o    = s2_pass_q;

endmodule
